// File: rtl/gf2mz_scalar_mul.sv
// -----------------------------------------------------------------------------
// gf2mz_scalar_mul
//   Computes C(z) = s * A(z) over GF(2^M)[z]. A is an N-coefficient polynomial
//   stored word-packed in RAM, D field elements per word. Element k = addr*D+j
//   sits in bits [M*j +: M] of word addr. The block reads one word at a time
//   and runs D bit-serial (MSB-first) GF(2^M) multipliers in parallel, all
//   sharing the scalar s. It then writes the product word to the result RAM
//   at the same address. Lanes with k >= N are tail padding and are written
//   as zero. The result RAM feeds gf2mz_add as its B operand.
//
//   Timing per word: DELAY_RD read cycles + M multiply cycles + 1 write cycle.
//
// Ports
//   clk     in   1            clock, rising edge
//   rst_b   in   1            asynchronous reset, active low
//   start   in   1            begin operation (sampled only while idle)
//   s_di    in   M            scalar s, latched on an accepted start
//   A_di    in   WIDTH        A RAM read data
//   A_addr  out  AW           A RAM read address
//   C_do    out  WIDTH        result write data (zero when C_we is low)
//   C_addr  out  AW           result write address (always equal to A_addr)
//   C_we    out  1            result write enable, single-cycle pulse
//   busy    out  1            high from accepted start until done
//   done    out  1            single-cycle completion pulse
// -----------------------------------------------------------------------------
module gf2mz_scalar_mul #(
  parameter int          N        = 47,
  parameter int          M        = 101,
  parameter int          D        = 6,
  parameter logic [M-1:0] POLY    = M'('hC3),
  parameter int          DELAY_RD = 1,
  localparam int         WIDTH    = M * D,
  localparam int         DEPTH    = (N + D - 1) / D,
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [M-1:0]     s_di,
  input  logic [WIDTH-1:0] A_di,
  output logic [AW-1:0]    A_addr,
  output logic [WIDTH-1:0] C_do,
  output logic [AW-1:0]    C_addr,
  output logic             C_we,
  output logic             busy,
  output logic             done
);

  localparam int BW  = $clog2(M);
  localparam int RDW = (DELAY_RD > 1) ? $clog2(DELAY_RD) : 1;

  localparam logic [AW-1:0]  ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [BW-1:0]  BIT_MSB   = BW'(M - 1);
  localparam logic [RDW-1:0] RD_LAST   = RDW'(DELAY_RD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MUL   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [M-1:0]     s_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] acc;
  logic [BW-1:0]    bit_idx;
  logic [RDW-1:0]   rd_cnt;
  logic             c_we;

  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] acc_next;

  // Multiply by x modulo f(x); x^M is implicit in POLY.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  // Tail lanes are zeroed when the operand word is captured; a zero operand
  // keeps its accumulator at zero, so the written word is already padded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    lane_mask = '0;
    for (int j = 0; j < D; j++) begin
      if (int'(addr) * D + j < N) lane_mask[j*M +: M] = '1;
    end
  end

  // One MSB-first Horner step per lane: acc = acc*x + s_bit*a.
  always_comb begin
    acc_next = '0;
    for (int j = 0; j < D; j++) begin
      acc_next[j*M +: M] = xtime(acc[j*M +: M]) ^
                           (s_reg[bit_idx] ? a_reg[j*M +: M] : '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      // NOTE: the wide datapath registers are reset too; the outputs must be
      // zero immediately on reset and they are small enough to be flops.
      state   <= IDLE;
      addr    <= '0;
      s_reg   <= '0;
      a_reg   <= '0;
      acc     <= '0;
      bit_idx <= '0;
      rd_cnt  <= '0;
      c_we    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s_reg  <= s_di;
            addr   <= '0;
            rd_cnt <= '0;
            busy   <= 1'b1;
            state  <= READ;
          end
        end

        READ: begin
          // Address is stable for the whole read window; capture on its last cycle.
          if (rd_cnt == RD_LAST) begin
            a_reg   <= A_di & lane_mask;
            acc     <= '0;
            bit_idx <= BIT_MSB;
            rd_cnt  <= '0;
            state   <= MUL;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        MUL: begin
          acc <= acc_next;
          if (bit_idx == '0) begin
            c_we  <= 1'b1;
            state <= WRITE;
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end

        WRITE: begin
          c_we <= 1'b0;
          if (addr == ADDR_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            addr  <= addr + 1'b1;
            state <= READ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign A_addr = addr;
  assign C_addr = addr;
  assign C_we   = c_we;
  assign C_do   = c_we ? acc : '0;

endmodule

// File: tb/tb_gf2mz_scalar_mul.sv
module tb_gf2mz_scalar_mul;

  localparam int N     = 47;
  localparam int M     = 101;
  localparam int D     = 6;
  localparam int W     = M * D;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam logic [M-1:0] POLY = M'('hC3);
  localparam int LATENCY = 825;
  localparam int WORD_CYC = M + 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start;
  logic [M-1:0]  s_di;
  logic [W-1:0]  A_di;
  logic [AW-1:0] A_addr;
  logic [W-1:0]  C_do;
  logic [AW-1:0] C_addr;
  logic          C_we;
  logic          busy;
  logic          done;

  logic [W-1:0]  a_mem   [DEPTH];
  logic [W-1:0]  exp_img [DEPTH];
  exp_t          exp_q   [$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic prev_done = 1'b0;

  gf2mz_scalar_mul dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .s_di   (s_di),
    .A_di   (A_di),
    .A_addr (A_addr),
    .C_do   (C_do),
    .C_addr (C_addr),
    .C_we   (C_we),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign A_di = a_mem[A_addr];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // LSB-first shift-and-add reference multiplier.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r  = '0;
    logic [M-1:0] aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r ^= aa;
      aa = {aa[M-2:0], 1'b0} ^ (aa[M-1] ? POLY : '0);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
    return r[M-1:0];
  endfunction

  // Random A with the tail lanes (k >= N) left zero.
  task automatic fill_random_a();
    for (int a = 0; a < DEPTH; a++) begin
      a_mem[a] = '0;
      for (int j = 0; j < D; j++)
        if (a * D + j < N) a_mem[a][j*M +: M] = rand_elem();
    end
  endtask

  task automatic model_expected(input logic [M-1:0] s);
    for (int a = 0; a < DEPTH; a++) begin
      exp_img[a] = '0;
      for (int j = 0; j < D; j++)
        if (a * D + j < N) exp_img[a][j*M +: M] = gf_mul(a_mem[a][j*M +: M], s);
    end
  endtask

  // Scoreboard monitor: compares every write against the queued expectation.
  always @(negedge clk) begin
    if (rst_b) begin
      check("addr_alias", W'(A_addr), W'(C_addr));
      if (prev_done) check("done_pulse", W'(done), W'(0));
      if (C_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", W'(1), W'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", W'(C_addr), W'(e.addr));
          check("wr_data", C_do, e.data);
        end
      end else begin
        check("c_do_idle", C_do, '0);
      end
    end
    prev_done <= done && rst_b;
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, W'({busy, done, C_we, A_addr, C_addr}), W'(0));
    check({name, "_cdo"}, C_do, '0);
  endtask

  // Issues one operation from exp_img/a_mem. Called at a negedge; returns at
  // the negedge where done is high (or after an abort by reset).
  task automatic do_op(input logic [M-1:0] s, input int repulse_at, input int rst_at);
    int t0;
    for (int a = 0; a < DEPTH; a++) exp_q.push_back('{addr: AW'(a), data: exp_img[a]});
    start = 1'b1;
    s_di  = s;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    s_di  = ~s;
    while (!done && (cyc - t0) < LATENCY + 50) begin
      if (repulse_at != 0 && (cyc - t0) == repulse_at) begin
        start = 1'b1;
        s_di  = rand_elem();
      end
      if (rst_at != 0 && (cyc - t0) == rst_at) begin
        rst_b = 1'b0;
        #1;
        check_all_zero("abort_rst");
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", W'(done), W'(0));
        end
        check("abort_left", W'(exp_q.size()), W'(DEPTH - rst_at / WORD_CYC));
        exp_q.delete();
        rst_b = 1'b1;
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    check("done_latency", W'(cyc - t0), W'(LATENCY));
    check("busy_after", W'(busy), W'(0));
    check("all_written", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    logic [M-1:0] s;
    rst_b = 1'b0;
    start = 1'b0;
    s_di  = '0;
    for (int a = 0; a < DEPTH; a++) a_mem[a] = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_b = 1'b1;
    @(negedge clk);

    // s = 1: C equals A.
    fill_random_a();
    for (int a = 0; a < DEPTH; a++) exp_img[a] = a_mem[a];
    do_op(M'(1), 0, 0);

    // s = 0 with all-ones A: every word zero. Issued in the done cycle.
    for (int a = 0; a < DEPTH; a++) begin
      a_mem[a]   = '1;
      exp_img[a] = '0;
    end
    do_op(M'(0), 0, 0);

    // s = x, A coeff 0 = x^100: C coeff 0 = x^101 mod f.
    for (int a = 0; a < DEPTH; a++) begin
      a_mem[a]   = '0;
      exp_img[a] = '0;
    end
    a_mem[0][M-1]    = 1'b1;
    exp_img[0][M-1:0] = M'('hC3);
    do_op(M'(2), 0, 0);

    // Tail lane k = 47 holds 1; it must be written as 0.
    fill_random_a();
    a_mem[7][5*M +: M] = M'(1);
    for (int a = 0; a < DEPTH; a++) exp_img[a] = a_mem[a];
    exp_img[7][5*M +: M] = '0;
    do_op(M'(1), 0, 0);

    // Start re-pulsed while busy is ignored.
    fill_random_a();
    s = rand_elem();
    model_expected(s);
    do_op(s, 100, 0);

    // Reset mid-operation, then restart the same job.
    do_op(s, 0, 300);
    @(negedge clk);
    do_op(s, 0, 0);

    // Random pairs against the reference model.
    for (int t = 0; t < 40; t++) begin
      fill_random_a();
      s = rand_elem();
      model_expected(s);
      do_op(s, 0, 0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
